// File: rtl/vcve2_vec_ex_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : vcve2_vec_ex_seq                                             |
// | Purpose  : Steps one vector instruction through the scalar EX block one |
// |            32-bit word at a time with byte-masked write-back strobes.   |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module vcve2_vec_ex_seq #(
   parameter int VLEN = 128
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         start_i,
   input  logic [$clog2(VLEN/8):0]                      vl_i,
   input  logic [2:0]                                   vsew_i,
   input  logic                                         kill_i,
   input  logic                                         ex_valid_i,
   output logic                                         ready_o,
   output logic                                         busy_o,
   output logic                                         ex_req_o,
   output logic                                         first_cycle_o,
   output logic [((VLEN/32 > 1) ? $clog2(VLEN/32) : 1)-1:0] word_idx_o,
   output logic [2:0]                                   vsew_o,
   output logic                                         wr_en_o,
   output logic [3:0]                                   wr_be_o,
   output logic                                         done_o,
   output logic                                         illegal_o
);

   localparam int c_nw        = VLEN / 32;
   localparam int c_vlw       = $clog2(VLEN/8) + 1;
   localparam int c_iw        = (c_nw > 1) ? $clog2(c_nw) : 1;
   localparam int c_bw        = c_vlw + 3;
   localparam int c_max_bytes = VLEN / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_iw-1:0]   r_idx;
   logic [c_iw-1:0]   r_last_idx;
   logic [1:0]        r_tail;
   logic [2:0]        r_vsew;
   logic              r_illegal;
   logic              r_first;

   logic [c_bw-1:0]   w_bytes;
   logic [c_bw-1:0]   w_bytes_m1;
   logic              w_illegal;
   logic              w_accept;
   logic              w_advance;
   logic              w_last;
   logic [3:0]        w_tail_be;
   logic              w_unused;

   // Length arithmetic on the issue-time inputs; only consumed on accept.
   assign w_bytes    = c_bw'(vl_i) << vsew_i[1:0];
   assign w_bytes_m1 = w_bytes - c_bw'(1);
   assign w_illegal  = vsew_i[2] | (&vsew_i[1:0]) | (w_bytes > c_bw'(c_max_bytes));
   assign w_unused   = ^{w_bytes_m1[c_bw-1:c_iw+2], w_bytes_m1[1:0]};

   assign w_last = (r_idx == r_last_idx);

   always_comb begin
      w_tail_be = 4'b1111;
      case (r_tail)
         2'd1:    w_tail_be = 4'b0001;
         2'd2:    w_tail_be = 4'b0011;
         2'd3:    w_tail_be = 4'b0111;
         default: w_tail_be = 4'b1111;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_advance     = 1'b0;
      ex_req_o      = 1'b0;
      first_cycle_o = 1'b0;
      wr_en_o       = 1'b0;
      wr_be_o       = 4'b0000;
      done_o        = 1'b0;
      illegal_o     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i && !kill_i) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_illegal || (vl_i == '0)) ? S_DONE : S_EXEC;
            end
         end
         S_EXEC: begin
            ex_req_o = 1'b1;
            if (kill_i) begin
               w_state_nxt = S_IDLE;
            end else begin
               first_cycle_o = r_first;
               if (ex_valid_i) begin
                  wr_en_o = 1'b1;
                  wr_be_o = w_last ? w_tail_be : 4'b1111;
                  if (w_last) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_advance = 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            if (!kill_i) begin
               done_o    = 1'b1;
               illegal_o = r_illegal;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_last_idx <= '0;
         r_tail     <= 2'b00;
         r_vsew     <= 3'b000;
         r_illegal  <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_vsew     <= vsew_i;
            r_illegal  <= w_illegal;
            r_last_idx <= w_bytes_m1[c_iw+1:2];
            r_tail     <= w_bytes[1:0];
            r_idx      <= '0;
            r_first    <= 1'b1;
         end else if (w_advance) begin
            r_idx   <= r_idx + c_iw'(1);
            r_first <= 1'b1;
         end else begin
            r_first <= 1'b0;
         end
      end
   end

   assign ready_o    = (r_state == S_IDLE);
   assign busy_o     = (r_state != S_IDLE);
   assign word_idx_o = r_idx;
   assign vsew_o     = r_vsew;

endmodule
`default_nettype wire

// File: tb/tb_vcve2_vec_ex_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_vcve2_vec_ex_seq                                          |
// | Purpose  : Directed vector table plus stall, kill and reset sequences.  |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module tb_vcve2_vec_ex_seq;

   localparam int c_nw = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [4:0] vl_i;
   logic [2:0] vsew_i;
   logic       kill_i;
   logic       ex_valid_i;
   logic       ready_o, busy_o, ex_req_o, first_cycle_o;
   logic [1:0] word_idx_o;
   logic [2:0] vsew_o;
   logic       wr_en_o;
   logic [3:0] wr_be_o;
   logic       done_o, illegal_o;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] vsew;
      logic [4:0] vl;
      int         nw;
      logic [3:0] last_be;
      logic       ill;
   } vec_t;

   vec_t vecs[10];

   vcve2_vec_ex_seq #(.VLEN(128)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .vl_i          (vl_i),
      .vsew_i        (vsew_i),
      .kill_i        (kill_i),
      .ex_valid_i    (ex_valid_i),
      .ready_o       (ready_o),
      .busy_o        (busy_o),
      .ex_req_o      (ex_req_o),
      .first_cycle_o (first_cycle_o),
      .word_idx_o    (word_idx_o),
      .vsew_o        (vsew_o),
      .wr_en_o       (wr_en_o),
      .wr_be_o       (wr_be_o),
      .done_o        (done_o),
      .illegal_o     (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 unit after the rising edge; outputs are sampled 3 later.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"},   32'(ready_o), 1);
      chk({tag, "_busy"},    32'(busy_o), 0);
      chk({tag, "_ex_req"},  32'(ex_req_o), 0);
      chk({tag, "_first"},   32'(first_cycle_o), 0);
      chk({tag, "_idx"},     32'(word_idx_o), 0);
      chk({tag, "_vsew"},    32'(vsew_o), 0);
      chk({tag, "_wr_en"},   32'(wr_en_o), 0);
      chk({tag, "_wr_be"},   32'(wr_be_o), 0);
      chk({tag, "_done"},    32'(done_o), 0);
      chk({tag, "_illegal"}, 32'(illegal_o), 0);
   endtask

   task automatic run_vec(input vec_t v);
      int writes  = 0;
      int done_at = -1;
      int ill     = 0;
      cyc();
      vsew_i = v.vsew; vl_i = v.vl; start_i = 1'b1; ex_valid_i = 1'b1;
      #3;
      chk("vec_ready_at_accept", 32'(ready_o), 1);
      for (int c = 1; c <= c_nw + 3; c++) begin
         cyc();
         start_i = 1'b0;
         vl_i    = 5'($urandom);
         vsew_i  = 3'($urandom);
         #3;
         if (wr_en_o) begin
            chk("vec_wr_idx",   32'(word_idx_o), writes);
            chk("vec_wr_be",    32'(wr_be_o),
                (writes == v.nw - 1) ? 32'(v.last_be) : 32'hF);
            chk("vec_wr_first", 32'(first_cycle_o), 1);
            chk("vec_vsew_latched", 32'(vsew_o), 32'(v.vsew));
            writes++;
         end
         if (done_o && done_at < 0) begin
            done_at = c;
            ill     = 32'(illegal_o);
         end
         if (c == v.nw + 2) chk("vec_ready_after_done", 32'(ready_o), 1);
      end
      chk("vec_writes",  writes, v.nw);
      chk("vec_done_at", done_at, v.nw + 1);
      chk("vec_illegal", ill, 32'(v.ill));
   endtask

   initial begin
      int req1, first1, writes, done_at, dones;
      vecs[0] = '{3'b000, 5'd16, 4, 4'b1111, 1'b0};
      vecs[1] = '{3'b001, 5'd5,  3, 4'b0011, 1'b0};
      vecs[2] = '{3'b000, 5'd0,  0, 4'b1111, 1'b0};
      vecs[3] = '{3'b011, 5'd1,  0, 4'b1111, 1'b1};
      vecs[4] = '{3'b010, 5'd5,  0, 4'b1111, 1'b1};
      vecs[5] = '{3'b000, 5'd7,  2, 4'b0111, 1'b0};
      vecs[6] = '{3'b010, 5'd4,  4, 4'b1111, 1'b0};
      vecs[7] = '{3'b001, 5'd9,  0, 4'b1111, 1'b1};
      vecs[8] = '{3'b000, 5'd1,  1, 4'b0001, 1'b0};
      vecs[9] = '{3'b100, 5'd1,  0, 4'b1111, 1'b1};

      rst_ni = 1'b0; start_i = 1'b0; vl_i = '0; vsew_i = '0;
      kill_i = 1'b0; ex_valid_i = 1'b0;
      repeat (3) cyc();
      #3;
      chk_reset_outs("por");
      cyc();
      rst_ni = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Stall: vsew=32b, vl=3, EX not valid for two cycles on word 1.
      cyc();
      vsew_i = 3'b010; vl_i = 5'd3; start_i = 1'b1; ex_valid_i = 1'b1;
      req1 = 0; first1 = 0; writes = 0; done_at = -1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         start_i    = 1'b0;
         ex_valid_i = (c == 2 || c == 3) ? 1'b0 : 1'b1;
         #3;
         if (ex_req_o && word_idx_o == 2'd1) req1++;
         if (ex_req_o && word_idx_o == 2'd1 && first_cycle_o) first1++;
         if (c <= 5) chk("stall_first", 32'(first_cycle_o), (c == 3 || c == 4) ? 0 : 1);
         if (wr_en_o) writes++;
         if (done_o && done_at < 0) done_at = c;
      end
      chk("stall_req_word1",   req1, 3);
      chk("stall_first_word1", first1, 1);
      chk("stall_writes",      writes, 3);
      chk("stall_done_at",     done_at, 6);

      // Kill together with EX valid on word 1 of 4.
      cyc();
      vsew_i = 3'b000; vl_i = 5'd16; start_i = 1'b1; ex_valid_i = 1'b1;
      cyc();
      start_i = 1'b0;
      #3;
      chk("kill_w0_wr_en", 32'(wr_en_o), 1);
      cyc();
      kill_i = 1'b1;
      #3;
      chk("kill_wr_en", 32'(wr_en_o), 0);
      chk("kill_first", 32'(first_cycle_o), 0);
      cyc();
      kill_i = 1'b0;
      #3;
      chk("kill_idle_ready",  32'(ready_o), 1);
      chk("kill_idle_ex_req", 32'(ex_req_o), 0);
      dones = 0; writes = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         #3;
         if (done_o) dones++;
         if (wr_en_o) writes++;
      end
      chk("kill_no_done",   dones, 0);
      chk("kill_no_writes", writes, 0);

      // start coinciding with kill in IDLE must be dropped (vl=0 would pulse done).
      cyc();
      vl_i = 5'd0; start_i = 1'b1; kill_i = 1'b1;
      cyc();
      start_i = 1'b0; kill_i = 1'b0;
      #3;
      chk("kill_start_done", 32'(done_o), 0);
      chk("kill_start_busy", 32'(busy_o), 0);

      // Asynchronous reset in the middle of word 2.
      cyc();
      vsew_i = 3'b001; vl_i = 5'd8; start_i = 1'b1; ex_valid_i = 1'b1;
      cyc(); start_i = 1'b0;
      cyc();
      cyc();
      #3;
      chk("rst_mid_idx", 32'(word_idx_o), 2);
      #1;
      rst_ni = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      cyc();
      rst_ni = 1'b1;
      writes = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         #3;
         if (wr_en_o) writes++;
      end
      chk("rst_mid_no_writes", writes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/vcve2_vec_ex_seq.md
# vcve2_vec_ex_seq

Sequencer that runs one vector instruction through the scalar execution block one 32-bit word at a time. It latches `vl` and `vsew` at issue, steps a word index across the register group, and raises the EX request and first-cycle strobe per word. It waits for EX valid, then emits a byte-masked write-back strobe for each word. It sits between the ID-stage vector decode and `vcve2_ex_block`, gating `alu_instr_first_cycle_i` and the vector register-file write port.

## Interface
- `VLEN`, 128: vector register length in bits; power of two, ≥ 32. `NW = VLEN/32` words; `VLW = $clog2(VLEN/8)+1`.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  vector instruction issue; accepted only when `ready_o`=1
- `vl_i`  in  VLW  element count, sampled at accept
- `vsew_i`  in  3  element width, sampled at accept: 000=8b, 001=16b, 010=32b, others reserved
- `kill_i`  in  1  flush; aborts the sequence
- `ex_valid_i`  in  1  `ex_valid_o` from the EX block
- `ready_o`  out  1  idle, can accept
- `busy_o`  out  1  sequence in progress (EXEC or DONE)
- `ex_req_o`  out  1  current word is presented to EX
- `first_cycle_o`  out  1  first EX cycle of the current word
- `word_idx_o`  out  $clog2(NW) (min 1)  word being executed
- `vsew_o`  out  3  latched `vsew`, drives EX `vsew_i`
- `wr_en_o`  out  1  write-back strobe for `word_idx_o`
- `wr_be_o`  out  4  byte enables for the write
- `done_o`  out  1  one-cycle completion pulse
- `illegal_o`  out  1  qualifies `done_o`: the instruction was rejected

## Operation
- FSM states:
  - IDLE: `ready_o`=1.
  - EXEC: `ex_req_o`=1.
  - DONE: `done_o`=1.
- Length arithmetic is done at accept:
  - `bytes = vl_i << vsew_i[1:0]`.
  - `nwords = ceil(bytes/4)`.
  - `tail = bytes[1:0]`.
  - Registers hold `last_idx = nwords-1` and `tail`.
- Illegal at accept: `vsew_i` ≥ 011, or `vl_i` > VLEN/SEW (equivalently `bytes` > VLEN/8).
- IDLE → DONE when `start_i`, and either the instruction is illegal or `vl_i`=0. No EX request and no writes; `illegal_o` follows the illegal condition.
- IDLE → EXEC when `start_i` with a legal, nonzero `vl`. `word_idx_o` is set to 0.
- In EXEC:
  - `first_cycle_o`=1 in the first cycle after entering EXEC or advancing the index. It is 0 in later cycles of a multi-cycle word.
  - `ex_valid_i`=1 (and no kill) gives a combinational `wr_en_o`=1 in the same cycle.
  - Same-cycle `wr_be_o` is 4'b1111, except on word `last_idx` with `tail`≠0, where it is `(1<<tail)-1`. Tail bytes are left undisturbed.
  - If `word_idx_o`==`last_idx` → DONE; otherwise index+1 and stay in EXEC.
  - `ex_valid_i`=0: hold index, keep `ex_req_o`=1.
- DONE → IDLE unconditionally after one cycle.
- `kill_i` has priority in every state:
  - Next state is IDLE.
  - `wr_en_o`, `done_o` and `first_cycle_o` are forced to 0 in the kill cycle.
  - In IDLE, a `start_i` coinciding with `kill_i` is dropped.
- `start_i` outside IDLE is ignored; upstream must wait for `ready_o`.
- `wr_en_o`, `wr_be_o`, `first_cycle_o` are 0 whenever `ex_req_o`=0.
- `wr_be_o` reads 4'b0000 whenever `wr_en_o`=0.

## Timing
- Reset values:
  - State IDLE.
  - `ready_o`=1.
  - `busy_o`, `ex_req_o`, `first_cycle_o`, `wr_en_o`, `done_o`, `illegal_o` all 0.
  - `word_idx_o`=0, `vsew_o`=000, `wr_be_o`=0000.
- Reset asserted mid-sequence returns to IDLE immediately and asynchronously. No write is issued.
- Accept at cycle T. First `ex_req_o` at T+1. With single-cycle EX, word k writes at T+1+k and `done_o` fires at T+1+nwords.
- `vl`=0 or illegal: `done_o` at T+1, back in IDLE with `ready_o`=1 at T+2.
- Back-to-back throughput: the next accept happens no earlier than one cycle after `done_o`.
- Latched `vl`/`vsew` do not change during a sequence, whatever the inputs do.

## Test plan
- Reset with `rst_ni`=0 mid-EXEC at word 2 → all outputs at reset values in the same cycle; no `wr_en_o` afterwards.
- VLEN=128, `vsew`=000, `vl`=16, `ex_valid_i`=1 constant:
  - 4 writes at idx 0..3, all with be=1111.
  - `done_o` 5 cycles after accept, `illegal_o`=0.
- `vsew`=001, `vl`=5 → 3 words; be=1111, 1111, 0011; `done_o` 4 cycles after accept.
- `vsew`=010, `vl`=3, with `ex_valid_i` low for 2 cycles on word 1:
  - Word 1 holds `ex_req_o`=1 for 3 cycles.
  - `first_cycle_o` is high only in the first of those cycles.
  - 3 writes total.
- Edge cases on the done path:
  - `vl`=0 → `done_o` at T+1 with no `ex_req_o`.
  - `vsew`=011 → `done_o`+`illegal_o` at T+1.
  - `vsew`=010 with `vl`=5 (> 4) → `illegal_o`=1, no writes.
- `kill_i` together with `ex_valid_i` on word 1 of 4 → no `wr_en_o` that cycle; IDLE next cycle; `done_o` never asserted.
